// File: rtl/mx_pkg.sv
// mx_pkg: shared constants and types for the mx round-robin arbiter
package mx_pkg;

    localparam logic SRC0      = 1'b0;
    localparam logic SRC1      = 1'b1;
    localparam int   DW_DEF    = 32;
    localparam int   CNT_W_DEF = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

endpackage

// File: rtl/mx_rr_pick.sv
// mx_rr_pick: combinational two-way pick between requesters (round-robin or fixed priority)
module mx_rr_pick
    import mx_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic v1,
    input  logic v2,
    input  logic last_grant,
    output logic grant,
    output logic any_req
);

    // contested requests alternate under round-robin; idle cycles park on last_grant
    always_comb begin
        any_req = v1 | v2;
        grant   = (v1 & v2) ? (RR ? ~last_grant : SRC0)
                : v1        ? SRC0
                : v2        ? SRC1
                :             last_grant;
    end

endmodule

// File: rtl/mx_rr_arbiter.sv
// mx_rr_arbiter: arbitrates two valid/ready sources onto a registered one-entry output stage
module mx_rr_arbiter
    import mx_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter bit RR    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    MI1,
    input  logic             v1,
    output logic             r1,
    input  logic [DW-1:0]    MI2,
    input  logic             v2,
    output logic             r2,
    output logic             SMx,
    output logic [DW-1:0]    RMx,
    output logic             o_valid,
    output logic             o_src,
    input  logic             o_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    ostate_t state, state_nx;
    logic    last_grant;
    logic    grant;
    logic    any_req;
    logic    can_accept;
    logic    xfer;

    mx_rr_pick #(.RR(RR)) u_pick (
        .v1         (v1),
        .v2         (v2),
        .last_grant (last_grant),
        .grant      (grant),
        .any_req    (any_req)
    );

    assign o_valid = (state == FULL);

    // grants open only when the output stage is empty or draining this cycle
    always_comb begin
        can_accept = ~o_valid | o_ready;
        r1         = can_accept & any_req & (grant == SRC0);
        r2         = can_accept & any_req & (grant == SRC1);
        xfer       = r1 | r2;
        SMx        = grant;
        state_nx   = xfer                 ? FULL
                   : (o_valid & ~o_ready) ? FULL
                   :                        EMPTY;
    end

    // output register, fairness pointer and per-source counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            RMx        <= '0;
            o_src      <= SRC0;
            last_grant <= SRC1;
            cnt1       <= '0;
            cnt2       <= '0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                RMx        <= SMx ? MI2 : MI1;
                o_src      <= grant;
                last_grant <= grant;
            end
            if (r1) cnt1 <= cnt1 + 1'b1;
            if (r2) cnt2 <= cnt2 + 1'b1;
        end
    end

endmodule

// File: tb/tb_mx_rr_arbiter.sv
// tb_mx_rr_arbiter: scoreboard bench for round-robin and fixed-priority arbiter instances
module tb_mx_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] MI1 = '0, MI2 = '0;
    logic        v1 = 1'b0, v2 = 1'b0, o_ready = 1'b0;

    logic        a_r1, a_r2, a_smx, a_ov, a_src;
    logic [31:0] a_rmx;
    logic [15:0] a_c1, a_c2;
    logic        f_r1, f_r2, f_smx, f_ov, f_src;
    logic [31:0] f_rmx;
    logic [15:0] f_c1, f_c2;

    int errors = 0;
    int checks = 0;

    logic        m_valid, m_src, m_last;
    logic [31:0] m_data;
    logic [15:0] m_c1, m_c2;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    mx_rr_arbiter #(.DW(32), .CNT_W(16), .RR(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .MI1(MI1), .v1(v1), .r1(a_r1), .MI2(MI2), .v2(v2), .r2(a_r2),
        .SMx(a_smx), .RMx(a_rmx), .o_valid(a_ov), .o_src(a_src), .o_ready(o_ready),
        .cnt1(a_c1), .cnt2(a_c2)
    );

    mx_rr_arbiter #(.DW(32), .CNT_W(16), .RR(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .MI1(MI1), .v1(v1), .r1(f_r1), .MI2(MI2), .v2(v2), .r2(f_r2),
        .SMx(f_smx), .RMx(f_rmx), .o_valid(f_ov), .o_src(f_src), .o_ready(o_ready),
        .cnt1(f_c1), .cnt2(f_c2)
    );

    task automatic model_reset();
        m_valid = 1'b0; m_src = 1'b0; m_last = 1'b1; m_data = '0; m_c1 = '0; m_c2 = '0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; v1 = 1'b0; v2 = 1'b0; MI1 = '0; MI2 = '0; o_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // one cycle of the round-robin instance against the reference model and scoreboard
    task automatic tick();
        logic g, er1, er2, x;
        logic [32:0] e;
        @(negedge clk);
        g   = (v1 && v2) ? !m_last : (v1 ? 1'b0 : (v2 ? 1'b1 : m_last));
        er1 = (!m_valid || o_ready) && (v1 || v2) && !g;
        er2 = (!m_valid || o_ready) && (v1 || v2) && g;
        checks++;
        if ({a_r1, a_r2, a_smx} !== {er1, er2, g}) begin
            errors++;
            $display("FAIL grant: r1,r2,SMx=%b%b%b expected %b%b%b", a_r1, a_r2, a_smx, er1, er2, g);
        end
        x = er1 | er2;
        if (x) sb.push_back({g, g ? MI2 : MI1});
        @(posedge clk); #1;
        if (x) begin
            e = sb.pop_front();
            m_valid = 1'b1; m_src = e[32]; m_data = e[31:0]; m_last = e[32];
            if (e[32]) m_c2++; else m_c1++;
        end else if (o_ready) m_valid = 1'b0;
        checks++;
        if ({a_ov, a_src, a_rmx} !== {m_valid, m_src, m_data}) begin
            errors++;
            $display("FAIL output: valid,src,RMx=%b,%b,%h expected %b,%b,%h", a_ov, a_src, a_rmx, m_valid, m_src, m_data);
        end
        checks++;
        if ({a_c1, a_c2} !== {m_c1, m_c2}) begin
            errors++;
            $display("FAIL counters: cnt1,cnt2=%h,%h expected %h,%h", a_c1, a_c2, m_c1, m_c2);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_ov, a_src, a_rmx, a_c1, a_c2, f_ov, f_rmx, f_c1, f_c2} !== '0) begin
            errors++;
            $display("FAIL reset_state: rr ov=%b src=%b RMx=%h c1=%h c2=%h fp ov=%b RMx=%h c1=%h c2=%h",
                     a_ov, a_src, a_rmx, a_c1, a_c2, f_ov, f_rmx, f_c1, f_c2);
        end
    endtask

    task automatic test_single();
        do_reset();
        v1 = 1'b1; MI1 = 32'hAAAA0001; o_ready = 1'b1;
        tick();
        v1 = 1'b0;
        checks++;
        if ({a_ov, a_rmx, a_src, a_c1} !== {1'b1, 32'hAAAA0001, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL single: ov=%b RMx=%h src=%b cnt1=%h expected 1,aaaa0001,0,0001", a_ov, a_rmx, a_src, a_c1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic        es[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ed[4] = '{32'h11, 32'h22, 32'h11, 32'h22};
        do_reset();
        v1 = 1'b1; v2 = 1'b1; MI1 = 32'h11; MI2 = 32'h22; o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({a_ov, a_src, a_rmx} !== {1'b1, es[i], ed[i]}) begin
                errors++;
                $display("FAIL rr_seq[%0d]: ov=%b src=%b RMx=%h expected 1,%b,%h", i, a_ov, a_src, a_rmx, es[i], ed[i]);
            end
            checks++;
            if ({f_ov, f_src, f_rmx, f_r2} !== {1'b1, 1'b0, 32'h11, 1'b0}) begin
                errors++;
                $display("FAIL fp_seq[%0d]: ov=%b src=%b RMx=%h r2=%b expected 1,0,11,0", i, f_ov, f_src, f_rmx, f_r2);
            end
        end
        v1 = 1'b0; v2 = 1'b0;
        checks++;
        if ({a_c1, a_c2, f_c1, f_c2} !== {16'd2, 16'd2, 16'd4, 16'd0}) begin
            errors++;
            $display("FAIL b2b_counts: rr %0d,%0d fp %0d,%0d expected 2,2 4,0", a_c1, a_c2, f_c1, f_c2);
        end
    endtask

    task automatic test_stall();
        do_reset();
        v2 = 1'b1; MI2 = 32'h55; o_ready = 1'b0;
        tick();
        MI2 = 32'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({a_ov, a_rmx, a_r1, a_r2} !== {1'b1, 32'h55, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall[%0d]: ov=%b RMx=%h r1=%b r2=%b expected 1,55,0,0", i, a_ov, a_rmx, a_r1, a_r2);
            end
        end
        o_ready = 1'b1;
        #1;
        checks++;
        if (a_r2 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: r2=%b expected 1", a_r2);
        end
        tick();
        v2 = 1'b0;
        checks++;
        if ({a_rmx, a_src, a_c2} !== {32'h66, 1'b1, 16'd2}) begin
            errors++;
            $display("FAIL stall_next: RMx=%h src=%b cnt2=%h expected 66,1,0002", a_rmx, a_src, a_c2);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        v1 = 1'b1; MI1 = 32'h99; o_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        checks++;
        if (a_c1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_pre: cnt1=%h expected ffff", a_c1);
        end
        m_c1 = 16'hFFFF; m_valid = 1'b1; m_src = 1'b0; m_data = 32'h99; m_last = 1'b0;
        tick();
        v1 = 1'b0;
        checks++;
        if ({a_c1, f_c1} !== 32'h0) begin
            errors++;
            $display("FAIL wrap: rr cnt1=%h fp cnt1=%h expected 0000", a_c1, f_c1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        v1 = 1'b1; MI1 = 32'h77; o_ready = 1'b0;
        tick();
        v1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ov, a_rmx, a_c1, a_c2} !== '0) begin
            errors++;
            $display("FAIL async_reset: ov=%b RMx=%h cnt1=%h cnt2=%h expected all 0", a_ov, a_rmx, a_c1, a_c2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        v1 = 1'b1; v2 = 1'b1; MI1 = 32'h11; MI2 = 32'h22; o_ready = 1'b1;
        #1;
        checks++;
        if ({a_r1, a_r2} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_grant: r1,r2=%b%b expected 10", a_r1, a_r2);
        end
        tick();
        tick();
        v1 = 1'b0; v2 = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
